// File: rtl/seq_lock_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seq_lock_pkg
// Description : Shared types, button indices, segment glyphs and the
//               button-to-letter lookup for the seq_lock block.
// Revision    : 1.0 - initial release
// ============================================================================
package seq_lock_pkg;

    typedef enum logic [1:0] {
        FILL     = 2'd0,
        ARMED    = 2'd1,
        UNLOCKED = 2'd2,
        LOCKOUT  = 2'd3
    } state_t;

    localparam logic [2:0] BTN_U = 3'd0;
    localparam logic [2:0] BTN_D = 3'd1;
    localparam logic [2:0] BTN_L = 3'd2;
    localparam logic [2:0] BTN_R = 3'd3;
    localparam logic [2:0] BTN_C = 3'd4;

    // Active-low {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_U     = 7'b1000001;
    localparam logic [6:0] SEG_D     = 7'b0100001;
    localparam logic [6:0] SEG_L     = 7'b1000111;
    localparam logic [6:0] SEG_R     = 7'b0101111;
    localparam logic [6:0] SEG_C     = 7'b0100111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    function automatic logic [6:0] letter_of(input logic [2:0] idx);
        logic [6:0] r;
        case (idx)
            BTN_U:   r = SEG_U;
            BTN_D:   r = SEG_D;
            BTN_L:   r = SEG_L;
            BTN_R:   r = SEG_R;
            BTN_C:   r = SEG_C;
            default: r = SEG_BLANK;
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seq_lock_tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : tick_gen
// Description : Free-running divider; o_tick pulses for one cycle every
//               CLK_HZ/TICK_HZ clock cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module tick_gen #(
    parameter int CLK_HZ  = 100_000_000,
    parameter int TICK_HZ = 5
) (
    input  logic clk,
    input  logic rst_n,
    output logic o_tick
);

    localparam int c_div   = CLK_HZ / TICK_HZ;
    localparam int c_cnt_w = (c_div > 1) ? $clog2(c_div) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(c_div - 1);

    logic [c_cnt_w-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (r_cnt == c_cnt_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_tick = (r_cnt == c_cnt_last);

endmodule
`default_nettype wire

// File: rtl/seq_lock.sv
`default_nettype none
// ============================================================================
// Module      : seq_lock
// Description : Button-sequence lock with LED fill bar, next-letter display,
//               unlock latch and timed lockout after repeated failures.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_lock
    import seq_lock_pkg::*;
#(
    parameter int SEQ_LEN    = 3,
    parameter int LED_W      = 16,
    parameter int CLK_HZ     = 100_000_000,
    parameter int TICK_HZ    = 5,
    parameter int MAX_FAIL   = 3,
    parameter int LOCK_TICKS = 15
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [4:0]           btn,
    input  logic [3*SEQ_LEN-1:0] code,
    input  logic                 relock,
    output logic [LED_W-1:0]     led,
    output logic [3:0]           an,
    output logic [6:0]           seg,
    output logic                 unlocked,
    output logic                 lockout
);

    localparam int c_step_w = (SEQ_LEN > 1)  ? $clog2(SEQ_LEN)  : 1;
    localparam int c_fail_w = (MAX_FAIL > 1) ? $clog2(MAX_FAIL) : 1;
    localparam int c_fill_w = (LED_W > 2)    ? $clog2(LED_W)    : 1;
    localparam int c_lock_w = $clog2(LOCK_TICKS + 1);

    localparam logic [c_step_w-1:0] c_step_last = c_step_w'(SEQ_LEN - 1);
    localparam logic [c_fail_w-1:0] c_fail_last = c_fail_w'(MAX_FAIL - 1);
    localparam logic [c_fill_w-1:0] c_fill_last = c_fill_w'(LED_W - 2);
    localparam logic [c_lock_w-1:0] c_lock_last = c_lock_w'(LOCK_TICKS - 1);
    localparam logic [LED_W-1:0]    c_led_bar   = {1'b0, {(LED_W-1){1'b1}}};

    logic                w_tick;
    logic [4:0]          r_btn_q;
    logic [4:0]          w_press;
    logic                w_press_any;
    logic                w_press_one;
    logic [2:0]          w_press_idx;
    logic [2:0]          w_code_step;
    logic                w_match;

    state_t              r_state,  w_state_nxt;
    logic [c_step_w-1:0] r_step,   w_step_nxt;
    logic [c_fail_w-1:0] r_fail,   w_fail_nxt;
    logic [c_fill_w-1:0] r_fill,   w_fill_nxt;
    logic [c_lock_w-1:0] r_lock,   w_lock_nxt;

    logic [LED_W-1:0]    w_led,  r_led;
    logic [3:0]          w_an,   r_an;
    logic [6:0]          w_seg,  r_seg;
    logic [1:0]          w_digit;
    logic                r_unlocked;
    logic                r_lockout;

    tick_gen #(
        .CLK_HZ (CLK_HZ),
        .TICK_HZ(TICK_HZ)
    ) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .o_tick(w_tick)
    );

    // Rising-edge detect: a held button yields a single press
    assign w_press     = btn & ~r_btn_q;
    assign w_press_any = |w_press;
    assign w_press_one = $onehot(w_press);

    always_comb begin
        w_press_idx = 3'd0;
        for (int i = 0; i < 5; i++) begin
            if (w_press[i]) w_press_idx = 3'(i);
        end
    end

    // Code values 5..7 can never equal a press index, so they never match
    assign w_code_step = code[int'(r_step)*3 +: 3];
    assign w_match     = w_press_one && (w_press_idx == w_code_step);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_btn_q <= '0;
            r_state <= FILL;
            r_step  <= '0;
            r_fail  <= '0;
            r_fill  <= '0;
            r_lock  <= '0;
        end else begin
            r_btn_q <= btn;
            r_state <= w_state_nxt;
            r_step  <= w_step_nxt;
            r_fail  <= w_fail_nxt;
            r_fill  <= w_fill_nxt;
            r_lock  <= w_lock_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_step_nxt  = r_step;
        w_fail_nxt  = r_fail;
        w_fill_nxt  = r_fill;
        w_lock_nxt  = r_lock;
        case (r_state)
            FILL: begin
                if (w_tick) begin
                    if (r_fill == c_fill_last) begin
                        w_state_nxt = ARMED;
                    end else begin
                        w_fill_nxt = r_fill + 1'b1;
                    end
                end
            end
            ARMED: begin
                if (w_press_any) begin
                    if (w_match) begin
                        if (r_step == c_step_last) begin
                            w_state_nxt = UNLOCKED;
                            w_step_nxt  = '0;
                            w_fail_nxt  = '0;
                        end else begin
                            w_step_nxt = r_step + 1'b1;
                        end
                    end else begin
                        w_step_nxt = '0;
                        if (r_fail == c_fail_last) begin
                            w_state_nxt = LOCKOUT;
                            w_lock_nxt  = '0;
                        end else begin
                            w_fail_nxt = r_fail + 1'b1;
                        end
                    end
                end
            end
            LOCKOUT: begin
                // Tick phase is shared with the divider, so the first
                // lockout tick may arrive after less than a full period
                if (w_tick) begin
                    if (r_lock == c_lock_last) begin
                        w_state_nxt = ARMED;
                        w_step_nxt  = '0;
                        w_fail_nxt  = '0;
                        w_lock_nxt  = '0;
                    end else begin
                        w_lock_nxt = r_lock + 1'b1;
                    end
                end
            end
            UNLOCKED: begin
                if (relock) begin
                    w_state_nxt = ARMED;
                    w_step_nxt  = '0;
                end
            end
            default: begin
                w_state_nxt = FILL;
            end
        endcase
    end

    assign w_digit = 2'(r_step);

    always_comb begin
        w_led = '0;
        w_an  = 4'b1111;
        w_seg = SEG_BLANK;
        case (r_state)
            FILL: begin
                for (int i = 0; i < LED_W; i++) begin
                    w_led[i] = (i < int'(r_fill));
                end
            end
            ARMED: begin
                w_led = c_led_bar;
                w_an  = ~(4'b0001 << w_digit);
                w_seg = letter_of(w_code_step);
            end
            UNLOCKED: begin
                w_led = '1;
            end
            LOCKOUT: begin
                w_led = c_led_bar;
                w_an  = 4'b0000;
                w_seg = SEG_DASH;
            end
            default: begin
                w_led = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_led      <= '0;
            r_an       <= 4'b1111;
            r_seg      <= SEG_BLANK;
            r_unlocked <= 1'b0;
            r_lockout  <= 1'b0;
        end else begin
            r_led      <= w_led;
            r_an       <= w_an;
            r_seg      <= w_seg;
            r_unlocked <= (r_state == UNLOCKED);
            r_lockout  <= (r_state == LOCKOUT);
        end
    end

    assign led      = r_led;
    assign an       = r_an;
    assign seg      = r_seg;
    assign unlocked = r_unlocked;
    assign lockout  = r_lockout;

endmodule
`default_nettype wire

// File: tb/tb_seq_lock.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_lock
// Description : Directed self-checking bench for seq_lock (tick = 10 cycles,
//               8 LEDs, code L,D,C, two failures to lockout, 3-tick lockout).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_lock;

    localparam logic [4:0] B_U = 5'b00001;
    localparam logic [4:0] B_D = 5'b00010;
    localparam logic [4:0] B_L = 5'b00100;
    localparam logic [4:0] B_C = 5'b10000;

    localparam logic [6:0] G_L     = 7'b1000111;
    localparam logic [6:0] G_D     = 7'b0100001;
    localparam logic [6:0] G_C     = 7'b0100111;
    localparam logic [6:0] G_DASH  = 7'b0111111;
    localparam logic [6:0] G_BLANK = 7'h7F;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] btn;
    logic [8:0] code;
    logic       relock;
    logic [7:0] led;
    logic [3:0] an;
    logic [6:0] seg;
    logic       unlocked;
    logic       lockout;

    int passed = 0;
    int total  = 0;
    int cyc    = 0;

    seq_lock #(
        .SEQ_LEN   (3),
        .LED_W     (8),
        .CLK_HZ    (100),
        .TICK_HZ   (10),
        .MAX_FAIL  (2),
        .LOCK_TICKS(3)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn     (btn),
        .code    (code),
        .relock  (relock),
        .led     (led),
        .an      (an),
        .seg     (seg),
        .unlocked(unlocked),
        .lockout (lockout)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic press_btn(input logic [4:0] b);
        btn = b;
        step();
        btn = 5'b0;
        step();
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        btn    = 5'b0;
        relock = 1'b0;
        code   = {3'd4, 3'd1, 3'd2};
        repeat (3) step();
        total++; if (led !== 8'h00)     $display("FAIL reset_led: got %h want %h", led, 8'h00); else passed++;
        total++; if (an !== 4'b1111)    $display("FAIL reset_an: got %b want %b", an, 4'b1111); else passed++;
        total++; if (seg !== G_BLANK)   $display("FAIL reset_seg: got %b want %b", seg, G_BLANK); else passed++;
        total++; if (unlocked !== 1'b0) $display("FAIL reset_unlocked: got %b want 0", unlocked); else passed++;
        total++; if (lockout !== 1'b0)  $display("FAIL reset_lockout: got %b want 0", lockout); else passed++;
        rst_n = 1'b1;
        cyc   = 0;
    endtask

    // Presses inside the fill window must be ignored
    task automatic test_fill();
        int k;
        logic [7:0] exp_led;
        logic [3:0] exp_an;
        for (int c = 1; c <= 75; c++) begin
            if (c == 30) btn = B_U;
            if (c == 31) btn = 5'b0;
            if (c == 45) btn = B_L;
            if (c == 46) btn = 5'b0;
            step();
            k = (c >= 11) ? ((c - 1) / 10) : 0;
            if (k > 7) k = 7;
            exp_led = 8'((1 << k) - 1);
            exp_an  = (k == 7) ? 4'b1110 : 4'b1111;
            total++; if (led !== exp_led) $display("FAIL fill_led c=%0d: got %h want %h", c, led, exp_led); else passed++;
            total++; if (an !== exp_an)   $display("FAIL fill_an c=%0d: got %b want %b", c, an, exp_an); else passed++;
        end
        total++; if (seg !== G_L) $display("FAIL fill_seg: got %b want %b", seg, G_L); else passed++;
    endtask

    task automatic test_unlock();
        press_btn(B_L);
        total++; if (an !== 4'b1101) $display("FAIL unlock_an1: got %b want %b", an, 4'b1101); else passed++;
        total++; if (seg !== G_D)    $display("FAIL unlock_seg1: got %b want %b", seg, G_D); else passed++;
        press_btn(B_D);
        total++; if (an !== 4'b1011) $display("FAIL unlock_an2: got %b want %b", an, 4'b1011); else passed++;
        total++; if (seg !== G_C)    $display("FAIL unlock_seg2: got %b want %b", seg, G_C); else passed++;
        btn = B_C;
        step();
        total++; if (unlocked !== 1'b0) $display("FAIL unlock_latency: got %b want 0", unlocked); else passed++;
        btn = 5'b0;
        step();
        total++; if (unlocked !== 1'b1) $display("FAIL unlock_flag: got %b want 1", unlocked); else passed++;
        total++; if (led !== 8'hFF)     $display("FAIL unlock_led: got %h want %h", led, 8'hFF); else passed++;
        total++; if (an !== 4'b1111)    $display("FAIL unlock_an: got %b want %b", an, 4'b1111); else passed++;
        total++; if (seg !== G_BLANK)   $display("FAIL unlock_seg: got %b want %b", seg, G_BLANK); else passed++;
        press_btn(B_U);
        total++; if (unlocked !== 1'b1) $display("FAIL unlock_latched: got %b want 1", unlocked); else passed++;
    endtask

    task automatic test_relock();
        relock = 1'b1;
        step();
        relock = 1'b0;
        step();
        total++; if (led !== 8'h7F)     $display("FAIL relock_led: got %h want %h", led, 8'h7F); else passed++;
        total++; if (an !== 4'b1110)    $display("FAIL relock_an: got %b want %b", an, 4'b1110); else passed++;
        total++; if (seg !== G_L)       $display("FAIL relock_seg: got %b want %b", seg, G_L); else passed++;
        total++; if (unlocked !== 1'b0) $display("FAIL relock_flag: got %b want 0", unlocked); else passed++;
    endtask

    task automatic test_wrong_lockout();
        int a, t1, t3;
        logic exp_lo;
        press_btn(B_L);
        press_btn(B_U);
        total++; if (an !== 4'b1110)   $display("FAIL wrong_an: got %b want %b", an, 4'b1110); else passed++;
        total++; if (seg !== G_L)      $display("FAIL wrong_seg: got %b want %b", seg, G_L); else passed++;
        total++; if (lockout !== 1'b0) $display("FAIL wrong_nolock: got %b want 0", lockout); else passed++;
        press_btn(B_D);
        a  = cyc - 1;
        t1 = (a / 10 + 1) * 10;
        t3 = t1 + 20;
        total++; if (lockout !== 1'b1) $display("FAIL lock_flag: got %b want 1", lockout); else passed++;
        total++; if (an !== 4'b0000)   $display("FAIL lock_an: got %b want %b", an, 4'b0000); else passed++;
        total++; if (seg !== G_DASH)   $display("FAIL lock_seg: got %b want %b", seg, G_DASH); else passed++;
        total++; if (led !== 8'h7F)    $display("FAIL lock_led: got %h want %h", led, 8'h7F); else passed++;
        for (int g = 0; g < 60 && cyc <= t3; g++) begin
            if (cyc == t1 + 2) btn = B_L;
            if (cyc == t1 + 3) btn = 5'b0;
            step();
            exp_lo = (cyc <= t3);
            total++; if (lockout !== exp_lo) $display("FAIL lock_time cyc=%0d: got %b want %b", cyc, lockout, exp_lo); else passed++;
        end
        total++; if (an !== 4'b1110) $display("FAIL lock_exit_an: got %b want %b", an, 4'b1110); else passed++;
        total++; if (seg !== G_L)    $display("FAIL lock_exit_seg: got %b want %b", seg, G_L); else passed++;
    endtask

    task automatic test_held_simul();
        btn = B_L;
        repeat (50) step();
        total++; if (an !== 4'b1101) $display("FAIL held_an: got %b want %b", an, 4'b1101); else passed++;
        btn = 5'b0;
        step();
        total++; if (an !== 4'b1101) $display("FAIL held_release_an: got %b want %b", an, 4'b1101); else passed++;
        press_btn(B_L | B_D);
        total++; if (an !== 4'b1110)   $display("FAIL simul_an: got %b want %b", an, 4'b1110); else passed++;
        total++; if (lockout !== 1'b0) $display("FAIL simul_failclr: got %b want 0", lockout); else passed++;
        press_btn(B_U);
        total++; if (lockout !== 1'b1) $display("FAIL simul_lock: got %b want 1", lockout); else passed++;
    endtask

    task automatic test_reset_mid_lockout();
        repeat (3) step();
        total++; if (lockout !== 1'b1) $display("FAIL mid_lock_pre: got %b want 1", lockout); else passed++;
        rst_n = 1'b0;
        step();
        total++; if (led !== 8'h00)     $display("FAIL mid_rst_led: got %h want %h", led, 8'h00); else passed++;
        total++; if (an !== 4'b1111)    $display("FAIL mid_rst_an: got %b want %b", an, 4'b1111); else passed++;
        total++; if (seg !== G_BLANK)   $display("FAIL mid_rst_seg: got %b want %b", seg, G_BLANK); else passed++;
        total++; if (lockout !== 1'b0)  $display("FAIL mid_rst_lockout: got %b want 0", lockout); else passed++;
        total++; if (unlocked !== 1'b0) $display("FAIL mid_rst_unlocked: got %b want 0", unlocked); else passed++;
        rst_n = 1'b1;
        cyc   = 0;
        repeat (10) step();
        total++; if (led !== 8'h00) $display("FAIL refill_c10: got %h want %h", led, 8'h00); else passed++;
        step();
        total++; if (led !== 8'h01) $display("FAIL refill_c11: got %h want %h", led, 8'h01); else passed++;
    endtask

    initial begin
        test_reset();
        test_fill();
        test_unlock();
        test_relock();
        test_wrong_lockout();
        test_held_simul();
        test_reset_mid_lockout();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

endmodule
`default_nettype wire
